square_wave_detector: RTL and testbench



---
 rtl/square_wave_detector.sv | 161 ++++++++++++++++
 tb/tb_square_wave_detector.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/square_wave_detector.sv
// ============================================================================
//  Module      : square_wave_detector
//  Description : Slices a signed AXI4-Stream sample stream into a logic level
//                and tracks level transitions with a small FSM. For every
//                complete period it emits {high_count, period_count} on an
//                AXI4-Stream master. Counts are in accepted input samples.
//                Optional macro SQUARE_WAVE_DETECTOR_HYSTERESIS_EN selects the
//                THRESH_HI/THRESH_LO hysteresis slicer. When the macro is not
//                defined, a sign-based single-threshold slicer is used.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module square_wave_detector #(
    parameter int AXIS_DATA_WIDTH_IN = 14,
    parameter int CNT_WIDTH          = 32,
    parameter int THRESH_HI          = 512,
    parameter int THRESH_LO          = -512
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic                            enable,
    input  logic [AXIS_DATA_WIDTH_IN-1:0]   s_axis_tdata,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    output logic [2*CNT_WIDTH-1:0]          m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            overflow
);

    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_ARMED   = 2'd1,
        ST_HIGH    = 2'd2,
        ST_LOW     = 2'd3
    } state_t;

    state_t                     r_state;
    logic [CNT_WIDTH-1:0]       r_period_cnt;
    logic [CNT_WIDTH-1:0]       r_high_cnt;
    logic [2*CNT_WIDTH-1:0]     r_m_tdata;
    logic                       r_m_tvalid;
    logic                       r_overflow;

    logic                       w_is_high;
    logic                       w_is_low;
    logic                       w_accept;
    logic                       w_period_at_max;
    logic                       w_high_at_max;

`ifdef SQUARE_WAVE_DETECTOR_HYSTERESIS_EN
    localparam logic signed [AXIS_DATA_WIDTH_IN-1:0] c_THRESH_HI = THRESH_HI[AXIS_DATA_WIDTH_IN-1:0];
    localparam logic signed [AXIS_DATA_WIDTH_IN-1:0] c_THRESH_LO = THRESH_LO[AXIS_DATA_WIDTH_IN-1:0];

    logic signed [AXIS_DATA_WIDTH_IN-1:0] w_sample;

    // Hysteresis slicer: samples between the thresholds are neither high nor low
    always_comb begin
        w_sample  = $signed(s_axis_tdata);
        w_is_high = (w_sample >= c_THRESH_HI);
        w_is_low  = (w_sample <= c_THRESH_LO);
    end
`else
    // Thresholds have no effect in the sign-based slicer
    localparam int c_unused_thresh = THRESH_HI + THRESH_LO;

    // Sign slicer: zero and positive are high, negative is low
    always_comb begin
        w_is_high = ~s_axis_tdata[AXIS_DATA_WIDTH_IN-1];
        w_is_low  =  s_axis_tdata[AXIS_DATA_WIDTH_IN-1];
    end
`endif

    // Input ready: only stall on a pending result that is not being taken now
    assign s_axis_tready   = aresetn & enable & (~r_m_tvalid | m_axis_tready);
    assign w_accept        = s_axis_tvalid & s_axis_tready;
    assign w_period_at_max = (r_period_cnt == c_CNT_MAX);
    assign w_high_at_max   = (r_high_cnt == c_CNT_MAX);

    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tvalid = r_m_tvalid;
    assign overflow      = r_overflow;

    // Level-tracking FSM, saturating counters and one-entry result register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= ST_ACQUIRE;
            r_period_cnt <= '0;
            r_high_cnt   <= '0;
            r_m_tdata    <= '0;
            r_m_tvalid   <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            // A completed output handshake frees the register; a new load below wins
            if (r_m_tvalid && m_axis_tready) begin
                r_m_tvalid <= 1'b0;
            end

            if (!enable) begin
                // Drop any partial period; a pending result is left untouched
                r_state      <= ST_ACQUIRE;
                r_period_cnt <= '0;
                r_high_cnt   <= '0;
                r_overflow   <= 1'b0;
            end else if (w_accept) begin
                case (r_state)
                    ST_ACQUIRE: begin
                        if (w_is_low) begin
                            r_state <= ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        if (w_is_high) begin
                            r_state      <= ST_HIGH;
                            r_period_cnt <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                            r_high_cnt   <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                        end
                    end
                    ST_HIGH: begin
                        if (w_period_at_max) begin
                            r_overflow <= 1'b1;
                        end else begin
                            r_period_cnt <= r_period_cnt + 1'b1;
                        end
                        if (w_is_low) begin
                            // Falling-edge sample belongs to the low part of the period
                            r_state <= ST_LOW;
                        end else if (w_high_at_max) begin
                            r_overflow <= 1'b1;
                        end else begin
                            r_high_cnt <= r_high_cnt + 1'b1;
                        end
                    end
                    ST_LOW: begin
                        if (w_is_high) begin
                            // Rising edge closes the period; this sample opens the next
                            r_m_tdata    <= {r_high_cnt, r_period_cnt};
                            r_m_tvalid   <= 1'b1;
                            r_period_cnt <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                            r_high_cnt   <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                            r_state      <= ST_HIGH;
                        end else if (w_period_at_max) begin
                            r_overflow <= 1'b1;
                        end else begin
                            r_period_cnt <= r_period_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_ACQUIRE;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_square_wave_detector.sv
// ============================================================================
//  Module      : tb_square_wave_detector
//  Description : Directed self-checking bench for square_wave_detector in its
//                default (sign slicer) build. A 32-bit-counter instance and an
//                8-bit-counter instance share one input stream.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_square_wave_detector;

    localparam int c_W = 14;
    localparam logic [c_W-1:0] c_LO = 14'h3C00;   // -1024
    localparam logic [c_W-1:0] c_HI = 14'h0400;   // +1024
    localparam logic [c_W-1:0] c_P300 = 14'd300;
    localparam logic [c_W-1:0] c_M300 = 14'h3ED4; // -300
    localparam logic [c_W-1:0] c_ZERO = 14'h0000;
    localparam logic [c_W-1:0] c_M1 = 14'h3FFF;   // -1
    localparam logic [63:0] c_R_4_10 = {32'd4, 32'd10};

    logic            aclk;
    logic            aresetn;
    logic            enable;
    logic [c_W-1:0]  s_tdata;
    logic            s_tvalid;
    logic            s_tready;
    logic            s_tready8;
    logic [63:0]     m_tdata;
    logic            m_tvalid;
    logic            m_tready;
    logic            ovf;
    logic [15:0]     m8_tdata;
    logic            m8_tvalid;
    logic            ovf8;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] q[$];
    logic [15:0] q8[$];

    square_wave_detector dut (
        .aclk(aclk), .aresetn(aresetn), .enable(enable),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .overflow(ovf)
    );

    square_wave_detector #(.CNT_WIDTH(8)) dut8 (
        .aclk(aclk), .aresetn(aresetn), .enable(enable),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready8),
        .m_axis_tdata(m8_tdata), .m_axis_tvalid(m8_tvalid), .m_axis_tready(m_tready),
        .overflow(ovf8)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Record every output handshake, sampled on the falling edge
    always @(negedge aclk) begin
        if (aresetn && m_tvalid && m_tready) q.push_back(m_tdata);
        if (aresetn && m8_tvalid && m_tready) q8.push_back(m8_tdata);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one sample and wait (bounded) until it is accepted
    task automatic push(input logic [c_W-1:0] v);
        logic timed_out;
        timed_out = 1'b1;
        s_tdata  = v;
        s_tvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk);
            if (s_tready) begin
                @(posedge aclk);
                #1;
                timed_out = 1'b0;
                break;
            end
        end
        if (timed_out) check("push_timeout", {63'd0, timed_out}, 64'd0);
    endtask

    task automatic push_n(input logic [c_W-1:0] v, input int n);
        for (int i = 0; i < n; i++) push(v);
    endtask

    task automatic settle();
        s_tvalid = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        aresetn  = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = c_LO;
        repeat (3) @(posedge aclk);
        #1;
        aresetn  = 1'b1;
        s_tvalid = 1'b0;
        @(posedge aclk);
        #1;
        q.delete();
        q8.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        aresetn  = 1'b0;
        enable   = 1'b1;
        m_tready = 1'b1;
        s_tvalid = 1'b1;
        s_tdata  = c_LO;

        // Reset state with a valid input held
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_s_tready", {63'd0, s_tready}, 64'd0);
        check("rst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
        check("rst_m_tdata", m_tdata, 64'd0);
        check("rst_overflow", {63'd0, ovf}, 64'd0);
        do_reset();

        // Nominal stream: 4 high / 6 low
        push_n(c_LO, 6);
        push_n(c_HI, 4);
        push_n(c_LO, 6);
        push(c_HI);
        check("nom_latency_tvalid", {63'd0, m_tvalid}, 64'd1);
        check("nom_latency_tdata", m_tdata, c_R_4_10);
        for (int p = 0; p < 2; p++) begin
            push_n(c_HI, 3);
            push_n(c_LO, 6);
            push(c_HI);
        end
        settle();
        check("nom_count", q.size(), 64'd3);
        foreach (q[i]) check("nom_result", q[i], c_R_4_10);

        // Back-pressure: result held, input stalled, nothing lost
        do_reset();
        m_tready = 1'b0;
        push_n(c_LO, 6);
        push_n(c_HI, 4);
        push_n(c_LO, 6);
        push(c_HI);
        s_tdata  = c_HI;
        s_tvalid = 1'b1;
        repeat (5) @(negedge aclk);
        check("bp_s_tready", {63'd0, s_tready}, 64'd0);
        check("bp_m_tvalid", {63'd0, m_tvalid}, 64'd1);
        check("bp_hold_tdata", m_tdata, c_R_4_10);
        check("bp_no_handshake", q.size(), 64'd0);
        @(posedge aclk);
        #1;
        m_tready = 1'b1;
        push(c_HI);
        push_n(c_HI, 2);
        push_n(c_LO, 6);
        push(c_HI);
        settle();
        check("bp_count", q.size(), 64'd2);
        foreach (q[i]) check("bp_result", q[i], c_R_4_10);

        // Small alternating samples in a high plateau are edges for the sign slicer
        do_reset();
        push_n(c_LO, 6);
        push_n(c_HI, 2);
        push(c_P300);
        push(c_M300);
        push(c_P300);
        push(c_M300);
        push_n(c_HI, 2);
        push_n(c_LO, 6);
        push(c_HI);
        settle();
        check("sign_count", q.size(), 64'd3);
        if (q.size() == 3) begin
            check("sign_r0", q[0], {32'd3, 32'd4});
            check("sign_r1", q[1], {32'd1, 32'd2});
            check("sign_r2", q[2], {32'd2, 32'd8});
        end

        // Zero counts as high, -1 as low
        do_reset();
        push_n(c_M1, 3);
        push_n(c_ZERO, 2);
        push_n(c_M1, 2);
        push(c_ZERO);
        settle();
        check("zero_count", q.size(), 64'd1);
        if (q.size() == 1) check("zero_result", q[0], {32'd2, 32'd4});

        // Saturation: 300 high, 10 low on 32-bit and 8-bit counters
        do_reset();
        push(c_LO);
        push_n(c_HI, 300);
        push_n(c_LO, 10);
        push(c_HI);
        settle();
        check("sat32_count", q.size(), 64'd1);
        if (q.size() == 1) check("sat32_result", q[0], {32'd300, 32'd310});
        check("sat8_count", q8.size(), 64'd1);
        if (q8.size() == 1) check("sat8_result", {48'd0, q8[0]}, 64'h0000_0000_0000_FFFF);
        check("sat8_overflow", {63'd0, ovf8}, 64'd1);
        check("sat32_overflow", {63'd0, ovf}, 64'd0);

        // Enable drop mid-HIGH with a result pending
        m_tready = 1'b0;
        push_n(c_HI, 3);
        push_n(c_LO, 6);
        push(c_HI);
        settle();
        check("en_ovf_sticky", {63'd0, ovf8}, 64'd1);
        check("en_pending_tvalid", {63'd0, m_tvalid}, 64'd1);
        check("en_pending8", {48'd0, m8_tdata}, {48'd0, 8'd4, 8'd10});
        enable = 1'b0;
        @(posedge aclk);
        #1;
        enable = 1'b1;
        check("en_keep_tvalid", {63'd0, m_tvalid}, 64'd1);
        check("en_keep_tdata", m_tdata, c_R_4_10);
        check("en_ovf_clear", {63'd0, ovf8}, 64'd0);
        q.delete();
        m_tready = 1'b1;
        settle();
        check("en_deliver_count", q.size(), 64'd1);
        if (q.size() == 1) check("en_deliver_result", q[0], c_R_4_10);
        q.delete();
        push(c_HI);
        push_n(c_LO, 6);
        push_n(c_HI, 4);
        push_n(c_LO, 6);
        settle();
        check("en_no_early_result", q.size(), 64'd0);
        push(c_HI);
        settle();
        check("en_next_count", q.size(), 64'd1);
        if (q.size() == 1) check("en_next_result", q[0], c_R_4_10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
